// File: rtl/regfile_wb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_pkg
// Shared definitions for the register-file writeback controller:
//   - default data / address widths and queue depth
//   - source encoding used to remember which path won the last enqueue
// ---------------------------------------------------------------------------
package regfile_wb_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 4;
  localparam int DEPTH_DEFAULT  = 4;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// In-order writeback queue: storage, head/tail pointers and occupancy.
// Every entry and its valid bit are exported so the parent can search the
// queue for pending writes to a register.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   push, push_rd/data  enqueue one {rd, data} entry (caller guarantees !full)
//   pop                 drop the head entry (caller guarantees !empty)
//   ent_rd/ent_data     all storage slots, indexed by physical slot
//   ent_valid           slot currently holds a queued write
//   head_ptr            physical slot of the oldest entry
//   count               occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [ADDR_W-1:0]                 push_rd,
  input  logic [DATA_W-1:0]                 push_data,
  input  logic                              pop,
  output logic [DEPTH-1:0][ADDR_W-1:0]      ent_rd,
  output logic [DEPTH-1:0][DATA_W-1:0]      ent_data,
  output logic [DEPTH-1:0]                  ent_valid,
  output logic [$clog2(DEPTH)-1:0]          head_ptr,
  output logic [$clog2(DEPTH):0]            count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      rd_d[wr_ptr_q]   = push_rd;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Pointers wrap on their own; count alone tells full from empty.
    case ({push, pop})
      2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the queue and clears storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q     <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_q     <= rd_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    ent_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
    end
  end

  assign ent_rd   = rd_q;
  assign ent_data = data_q;
  assign head_ptr = rd_ptr_q;
  assign count    = count_q;

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_writeback_ctrl
// Write-side initiator for the register file. Arbitrates ALU and load
// writebacks into an in-order queue, drains one write per clock to the
// register file, and resolves the two read-port operands against writes
// still sitting in the queue.
// Optional feature macro: REGFILE_WB_BYPASS_EN
//   defined   - op1/op2 forwarded from the youngest matching queued write,
//               hazard1/hazard2 tied low
//   undefined - op1/op2 straight from the register file, hazardN flags a
//               pending write to rd_addrN so the pipeline can stall
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   alu_valid/ready, alu_rd/data    ALU writeback handshake and payload
//   ld_valid/ready, ld_rd/data      load writeback handshake and payload
//   wb_rd, wb_data, wb_wr           register file write port (head of queue)
//   rd_addr1/2, rf_data1/2          register file read addresses and data
//   op1, op2                        resolved operands
//   hazard1, hazard2                pending-write flags (no-bypass build)
//   q_count                         queue occupancy
// ---------------------------------------------------------------------------
module regfile_writeback_ctrl
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_rd,
  input  logic [DATA_W-1:0]        ld_data,
  output logic [ADDR_W-1:0]        wb_rd,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     wb_wr,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  input  logic [DATA_W-1:0]        rf_data1,
  input  logic [DATA_W-1:0]        rf_data2,
  output logic [DATA_W-1:0]        op1,
  output logic [DATA_W-1:0]        op2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  src_e                         last_grant_q, last_grant_d;
  logic                         full_s;
  logic                         alu_gnt_s, ld_gnt_s;
  logic                         alu_fire_s, ld_fire_s;
  logic                         push_s, pop_s;
  logic [ADDR_W-1:0]            push_rd_s;
  logic [DATA_W-1:0]            push_data_s;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_rd_s;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data_s;
  logic [DEPTH-1:0]             ent_valid_s;
  logic [PTR_W-1:0]             head_ptr_s;
  logic                         hit1_s, hit2_s;
`ifdef REGFILE_WB_BYPASS_EN
  logic [DATA_W-1:0]            fwd1_s, fwd2_s;
`endif

  assign full_s = (q_count == CNT_W'(DEPTH));

  // Grant: a lone valid source wins; on a tie the source that did not win
  // last time wins. With nobody valid both report ready.
  always_comb begin
    if (alu_valid && ld_valid) begin
      alu_gnt_s = (last_grant_q == SRC_LD);
      ld_gnt_s  = (last_grant_q == SRC_ALU);
    end else begin
      alu_gnt_s = !ld_valid;
      ld_gnt_s  = !alu_valid;
    end
  end

  // Ready looks only at registered occupancy, never at this cycle's pop.
  assign alu_ready  = !full_s && alu_gnt_s;
  assign ld_ready   = !full_s && ld_gnt_s;
  assign alu_fire_s = alu_valid && alu_ready;
  assign ld_fire_s  = ld_valid && ld_ready;
  assign push_s     = alu_fire_s || ld_fire_s;

  // Enqueue payload mux and last-grant tracking.
  always_comb begin
    if (ld_fire_s) begin
      push_rd_s    = ld_rd;
      push_data_s  = ld_data;
      last_grant_d = SRC_LD;
    end else if (alu_fire_s) begin
      push_rd_s    = alu_rd;
      push_data_s  = alu_data;
      last_grant_d = SRC_ALU;
    end else begin
      push_rd_s    = alu_rd;
      push_data_s  = alu_data;
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register; load wins the first tie after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= SRC_ALU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // The register file always accepts, so the head pops whenever it is shown.
  assign pop_s = wb_wr;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_rd   (push_rd_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .ent_rd    (ent_rd_s),
    .ent_data  (ent_data_s),
    .ent_valid (ent_valid_s),
    .head_ptr  (head_ptr_s),
    .count     (q_count)
  );

  assign wb_wr   = (q_count != {CNT_W{1'b0}});
  assign wb_rd   = ent_rd_s[head_ptr_s];
  assign wb_data = ent_data_s[head_ptr_s];

  // Queue search, oldest to youngest, so a later match overrides an earlier
  // one. The head is included: it is still being written this cycle.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx    = '0;
    hit1_s = 1'b0;
    hit2_s = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    fwd1_s = '0;
    fwd2_s = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr_s + PTR_W'(k);
      if (ent_valid_s[idx] && (ent_rd_s[idx] == rd_addr1)) begin
        hit1_s = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
        fwd1_s = ent_data_s[idx];
`endif
      end else begin
        hit1_s = hit1_s;
      end
      if (ent_valid_s[idx] && (ent_rd_s[idx] == rd_addr2)) begin
        hit2_s = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
        fwd2_s = ent_data_s[idx];
`endif
      end else begin
        hit2_s = hit2_s;
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign op1     = hit1_s ? fwd1_s : rf_data1;
  assign op2     = hit2_s ? fwd2_s : rf_data2;
  assign hazard1 = 1'b0;
  assign hazard2 = 1'b0;
`else
  assign op1     = rf_data1;
  assign op2     = rf_data2;
  assign hazard1 = hit1_s;
  assign hazard2 = hit2_s;
`endif

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback_ctrl
// Directed bench with a writeback scoreboard. Accepted handshakes push the
// expected {rd, data} into a queue; a monitor on the falling edge pops and
// compares whenever the DUT shows a write. Directed checks cover ready,
// arbitration order, occupancy, operand resolution and reset behaviour.
// ---------------------------------------------------------------------------
module tb_regfile_writeback_ctrl;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid;
  logic        alu_ready, ld_ready;
  logic [3:0]  alu_rd, ld_rd;
  logic [15:0] alu_data, ld_data;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_wr;
  logic [3:0]  rd_addr1, rd_addr2;
  logic [15:0] rf_data1, rf_data2;
  logic [15:0] op1, op2;
  logic        hazard1, hazard2;
  logic [2:0]  q_count;

  int  checks = 0;
  int  errors = 0;
  logic drain_en = 1'b1;
  wb_t exp_q[$];

  // Per-cycle payloads and expected winner (1 = load) for the tie tests.
  logic [3:0] t3_alu [4] = '{4'd1, 4'd1, 4'd2, 4'd2};
  logic [3:0] t3_ld  [4] = '{4'd9, 4'd10, 4'd10, 4'd11};
  logic       t3_ldw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] t4_alu [5] = '{4'd5, 4'd5, 4'd6, 4'd6, 4'd7};
  logic [3:0] t4_ld  [5] = '{4'd13, 4'd14, 4'd14, 4'd15, 4'd15};
  logic       t4_ldw [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  regfile_writeback_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_wr     (wb_wr),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rf_data1  (rf_data1),
    .rf_data2  (rf_data2),
    .op1       (op1),
    .op2       (op2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .q_count   (q_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare the shown write, then record new acceptances.
  always @(negedge clk) begin
    wb_t e;
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (drain_en && wb_wr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got rd %0h data %0h, expected no write at %0t",
                   wb_rd, wb_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", 32'(wb_data), 32'(e.data));
        end
      end
      if (alu_valid && alu_ready) exp_q.push_back({alu_rd, alu_data});
      if (ld_valid && ld_ready) exp_q.push_back({ld_rd, ld_data});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
    alu_rd = 4'h0; alu_data = 16'h0000; ld_rd = 4'h0; ld_data = 16'h0000;
    rd_addr1 = 4'h0; rd_addr2 = 4'h0; rf_data1 = 16'h5A5A; rf_data2 = 16'h7777;

    // Reset held low, then released with no traffic.
    repeat (2) tick();
    check("rst_wb_wr", 32'(wb_wr), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_op1", 32'(op1), 32'h5A5A);
    check("rst_hazard1", 32'(hazard1), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("idle_wb_wr", 32'(wb_wr), 32'd0);
    check("idle_q_count", 32'(q_count), 32'd0);
    check("idle_alu_ready", 32'(alu_ready), 32'd1);
    check("idle_ld_ready", 32'(ld_ready), 32'd1);
    rf_data1 = 16'hC3C3;
    #1;
    check("idle_op1_follows", 32'(op1), 32'hC3C3);

    // Single ALU write rd A / 1B50.
    tick();
    alu_valid = 1'b1; alu_rd = 4'hA; alu_data = 16'h1B50;
    rd_addr1 = 4'hA; rf_data1 = 16'h0000;
    #1;
    check("alu_ready_single", 32'(alu_ready), 32'd1);
    check("op1_before_accept", 32'(op1), 32'h0000);
    check("hazard1_before_accept", 32'(hazard1), 32'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    check("single_wb_wr", 32'(wb_wr), 32'd1);
    check("single_wb_rd", 32'(wb_rd), 32'hA);
    check("single_wb_data", 32'(wb_data), 32'h1B50);
    check("single_q_count", 32'(q_count), 32'd1);
`ifdef REGFILE_WB_BYPASS_EN
    check("single_op1_fwd", 32'(op1), 32'h1B50);
    check("single_hazard1", 32'(hazard1), 32'd0);
`else
    check("single_op1_rf", 32'(op1), 32'h0000);
    check("single_hazard1", 32'(hazard1), 32'd1);
`endif
    tick();
    check("single_drained", 32'(q_count), 32'd0);
    check("single_hazard1_clear", 32'(hazard1), 32'd0);
    rd_addr1 = 4'h0;

    // Both sources valid for four cycles: LD, ALU, LD, ALU.
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; ld_valid = 1'b1;
      alu_rd = t3_alu[i]; alu_data = {12'h100, t3_alu[i]};
      ld_rd  = t3_ld[i];  ld_data  = {12'h200, t3_ld[i]};
      #1;
      check("tie_ld_ready", 32'(ld_ready), 32'(t3_ldw[i]));
      check("tie_alu_ready", 32'(alu_ready), 32'(!t3_ldw[i]));
      check("tie_q_count", 32'(q_count), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    repeat (3) tick();
    check("tie_drained", 32'(q_count), 32'd0);

    // Fill with the consumer stalled.
    force dut.pop_s = 1'b0;
    drain_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; ld_valid = 1'b1;
      alu_rd = t4_alu[i]; alu_data = {12'h300, t4_alu[i]};
      ld_rd  = t4_ld[i];  ld_data  = {12'h400, t4_ld[i]};
      #1;
      check("fill_q_count", 32'(q_count), 32'(i));
      check("fill_ld_ready", 32'(ld_ready), 32'(t4_ldw[i] && (i < 4)));
      check("fill_alu_ready", 32'(alu_ready), 32'(!t4_ldw[i] && (i < 4)));
      if (i < 4) tick();
    end
    release dut.pop_s;
    drain_en = 1'b1;
    #1;
    check("full_wb_wr", 32'(wb_wr), 32'd1);
    check("full_alu_ready_pop", 32'(alu_ready), 32'd0);
    check("full_ld_ready_pop", 32'(ld_ready), 32'd0);
    tick();
    #1;
    check("after_pop_q_count", 32'(q_count), 32'd3);
    check("after_pop_ld_ready", 32'(ld_ready), 32'd1);
    check("after_pop_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0;
    #1;
    check("push_pop_q_count", 32'(q_count), 32'd3);
    repeat (4) tick();
    check("fill_drained", 32'(q_count), 32'd0);

    // Two queued writes to r3, youngest must win; then reset mid-cycle.
    force dut.pop_s = 1'b0;
    drain_en = 1'b0;
    alu_valid = 1'b1; alu_rd = 4'h3; alu_data = 16'h2D50;
    tick();
    alu_data = 16'hF612;
    tick();
    alu_valid = 1'b0;
    rd_addr2 = 4'h3;
    #1;
    check("dup_q_count", 32'(q_count), 32'd2);
    check("dup_head_rd", 32'(wb_rd), 32'h3);
    check("dup_head_data", 32'(wb_data), 32'h2D50);
`ifdef REGFILE_WB_BYPASS_EN
    check("dup_op2_youngest", 32'(op2), 32'hF612);
    check("dup_hazard2", 32'(hazard2), 32'd0);
`else
    check("dup_op2_rf", 32'(op2), 32'h7777);
    check("dup_hazard2", 32'(hazard2), 32'd1);
`endif
    rd_addr2 = 4'h4;
    #1;
    check("miss_op2", 32'(op2), 32'h7777);
    check("miss_hazard2", 32'(hazard2), 32'd0);
    rd_addr2 = 4'h3;
    ld_valid = 1'b1; ld_rd = 4'h7; ld_data = 16'h0777;
    tick();
    ld_valid = 1'b0;
    #1;
    check("pre_rst_q_count", 32'(q_count), 32'd3);
    rst = 1'b0;
    #1;
    check("midrst_wb_wr", 32'(wb_wr), 32'd0);
    check("midrst_q_count", 32'(q_count), 32'd0);
    check("midrst_wb_rd", 32'(wb_rd), 32'd0);
    check("midrst_wb_data", 32'(wb_data), 32'd0);
    check("midrst_op2", 32'(op2), 32'h7777);
    check("midrst_hazard2", 32'(hazard2), 32'd0);
    release dut.pop_s;
    drain_en = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    check("post_rst_q_count", 32'(q_count), 32'd0);
    repeat (3) tick();
    check("post_rst_idle_wr", 32'(wb_wr), 32'd0);
    check("post_rst_idle_count", 32'(q_count), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_ctrl.md
# regfile_writeback_ctrl

Write-side initiator for the 16-entry, 16-bit register file: collects writeback requests from the ALU and load paths, buffers them in a small in-order queue, and drives the register file's destination address, write data and write enable, one write per clock. It sits between execute/memory and the register file. It also supplies forwarded operands to the register file's two read ports while writes are still queued, so no operand is read stale.

## Interface
- DATA_W, 16: register data width
- ADDR_W, 4: register address width; the register file has 2**ADDR_W entries
- DEPTH, 4: queue entries; power of two, at least 2
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- alu_valid / alu_ready  in / out  1  ALU writeback handshake
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid / ld_ready  in / out  1  load writeback handshake
- ld_rd  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- wb_rd  out  ADDR_W  to register file Rd
- wb_data  out  DATA_W  to register file RW
- wb_wr  out  1  to register file wr
- rd_addr1, rd_addr2  in  ADDR_W  the Rs and Rt currently presented to the register file
- rf_data1, rf_data2  in  DATA_W  register file Rout1 and Rout2
- op1, op2  out  DATA_W  resolved operands
- hazard1, hazard2  out  1  operand depends on a queued write (bypass compiled out only)
- q_count  out  log2(DEPTH)+1  occupancy

## Operation
- Acceptance:
  - full = (q_count == DEPTH).
  - At most one enqueue per cycle.
  - A source's ready is asserted only when the queue is not full and that source holds the grant.
  - Ready never depends on the same-cycle dequeue.
- Arbitration:
  - When only one source is valid, it holds the grant.
  - When both are valid, grant goes to the source not recorded in last_grant.
  - last_grant updates only on an accepted enqueue.
  - Reset value of last_grant is ALU, so load wins the first tie.
- Queue: FIFO ordering. An entry's {rd, data} is captured on the edge where valid and ready are both high.
- Drain:
  - wb_wr = !empty.
  - wb_rd and wb_data show the head entry.
  - The head is popped on every edge where wb_wr = 1. The register file always accepts.
- Simultaneous enqueue and dequeue: q_count is unchanged and both pointers advance.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by q_count.
- Bypass lookup (both read ports independently):
  - Compare rd_addr against every valid queue entry, including the head being written this cycle.
  - The youngest match supplies op; otherwise op = rf_data.
- R0 gets no special treatment; it is written and forwarded like any other register.
- Reset (asynchronous, mid-operation):
  - Queue is emptied: q_count = 0, pointers 0, entry storage cleared.
  - wb_wr = 0, wb_rd = 0, wb_data = 0.
  - With no valid source, alu_ready = ld_ready = 1.
  - op1 = rf_data1 and op2 = rf_data2.
  - hazard1 = hazard2 = 0.
  - Queued writes are lost.

## Timing
- An entry accepted at edge N with the queue empty:
  - appears on wb_* during cycle N+1;
  - is written into the register file at edge N+1;
  - reads back from the register file from cycle N+2.
- From edge N onward, that entry is visible to the bypass lookup, so op reflects it in cycle N+1.
- Throughput: one write per cycle. Sustained back-to-back single-source traffic never fills the queue.
- ready, op and hazard are combinational from the current inputs and state.
- wb_* are combinational from registered state only.

## Configuration
- REGFILE_WB_BYPASS_EN defined:
  - op1 and op2 are forwarded as described above.
  - hazard1 = hazard2 = 0 constantly.
- REGFILE_WB_BYPASS_EN undefined:
  - op1 = rf_data1 and op2 = rf_data2 always.
  - hazardN = 1 whenever rd_addrN matches any valid entry; the pipeline stalls on it.

## Structure
- Package regfile_wb_pkg holds:
  - DATA_W and ADDR_W defaults;
  - the source encoding (SRC_ALU = 0, SRC_LD = 1) used for last_grant.
- One sub-module, wb_fifo, holds the storage, pointers and count. It exports all entries plus their valid bits for the match logic.
- Arbitration and bypass stay in the top level.

## Test plan
- Reset held low, then released with no traffic:
  - wb_wr = 0 and q_count = 0;
  - alu_ready = ld_ready = 1;
  - op1 follows rf_data1.
- ALU writes rd = 4'hA, data = 16'h1B50 at edge N:
  - cycle N+1 shows wb_wr = 1, wb_rd = 4'hA, wb_data = 16'h1B50;
  - rd_addr1 = 4'hA gives op1 = 16'h1B50 while rf_data1 is still old.
- Both sources valid for 4 cycles (ALU rd 1..4, load rd 9..12):
  - acceptances alternate LD, ALU, LD, ALU;
  - wb_rd sequence is 9, 1, 10, 2 in consecutive cycles.
- Queue fill, with wb draining and arrivals at one per cycle plus a stalled consumer modelled by forcing no dequeue, DEPTH = 4:
  - q_count reaches 4 and both readies drop;
  - after one pop, a single ready returns.
- Two queued writes to rd 4'h3, first 16'h2D50 then 16'hF612:
  - rd_addr2 = 3 gives op2 = 16'hF612 (youngest wins);
  - with the macro undefined, hazard2 = 1 and op2 = rf_data2.
- rst driven low with 3 entries queued, mid-cycle:
  - wb_wr drops immediately;
  - after release q_count = 0 and no stale write occurs.
